// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// Line levels and the FSM state encoding live here so the top and sub-module agree.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // The line idles low, so a frame opens with a high start bit and closes low.
  localparam logic IDLE_LVL  = 1'b0;
  localparam logic START_LVL = ~IDLE_LVL;
  localparam logic STOP_LVL  = IDLE_LVL;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_rx_out_buf.sv
// Single-entry hold register between the frame FSM and the parallel consumer.
// A completed frame either loads, replaces a word being consumed, or is dropped with an overrun pulse.
module serial_rx_out_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              perr,
  input  logic              ferr,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  // The slot frees up in the same cycle it is consumed, so a completion then still loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load && (!dout_valid || dout_ready)) begin
        dout       <= word;
        parity_err <= perr;
        frame_err  <= ferr;
        dout_valid <= 1'b1;
      end else if (load) begin
        overrun <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Deserialises start/data/parity/stop frames from the shift stage into parallel words.
// Data arrives LSB-first; the FSM only advances on bit_en strobes.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              pbit;
  logic              done;
  logic              done_perr;
  logic              done_ferr;

  // done is a one-cycle completion pulse; shreg stays put in IDLE so the buffer can copy it next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      pbit      <= 1'b0;
      done      <= 1'b0;
      done_perr <= 1'b0;
      done_ferr <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (sin == START_LVL) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg <= {sin, shreg[DATA_W-1:1]};
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
          PARITY: begin
            pbit  <= sin;
            state <= STOP;
          end
          STOP: begin
            done      <= 1'b1;
            done_perr <= (PARITY_EN != 0) && ((^shreg ^ pbit) != (ODD_PARITY != 0));
            done_ferr <= (sin != STOP_LVL);
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  serial_rx_out_buf #(
    .DATA_W(DATA_W)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (done),
    .word      (shreg),
    .perr      (done_perr),
    .ferr      (done_ferr),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

endmodule
